network_div_seq_29s_13s_16: RTL and testbench

//  Inverse of the network's 16s x 13s -> 29s product stage: iterative signed divider, 29-bit dividend / 13-bit divisor -> 16-bit quotient.

---
 rtl/network_div_pkg.sv | 19 +
 rtl/network_div_fix.sv | 57 +++++
 rtl/network_div_seq_29s_13s_16.sv | 144 ++++++++++++++
 tb/tb_network_div_seq_29s_13s_16.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/network_div_pkg.sv
// Shared widths, FSM state encoding and quotient limits for the sequential signed divider.
package network_div_pkg;

  localparam int DIVIDEND_W = 29;
  localparam int DIVISOR_W  = 13;
  localparam int QUOT_W     = 16;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic signed [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic signed [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

endpackage

// File: rtl/network_div_fix.sv
// Combinational sign restore and saturation of the unsigned divider result.
// The remainder path exists only when NETWORK_DIV_REM_EN is defined.
module network_div_fix
  import network_div_pkg::*;
(
  input  logic [DIVIDEND_W:0]  q_mag,
  input  logic                 neg_n,
  input  logic                 neg_d,
  input  logic                 dbz,
`ifdef NETWORK_DIV_REM_EN
  input  logic [DIVISOR_W-1:0] rem_mag,
  input  logic [DIVISOR_W-1:0] dvd_lo,
  output logic [DIVISOR_W-1:0] rem,
`endif
  output logic [QUOT_W-1:0]    quot,
  output logic                 sat
);

  localparam logic [DIVIDEND_W:0] POS_LIM =
    {{(DIVIDEND_W-QUOT_W+2){1'b0}}, {(QUOT_W-1){1'b1}}};
  localparam logic [DIVIDEND_W:0] NEG_LIM = POS_LIM + 1'b1;

  // Returns {clipped, quotient}; a negative result may reach exactly -2^(QUOT_W-1).
  function automatic logic [QUOT_W:0] sat_quot(input logic [DIVIDEND_W:0] mag,
                                               input logic neg);
    logic signed [QUOT_W-1:0] q;
    if (neg) begin
      if (mag > NEG_LIM) return {1'b1, QUOT_MIN};
      q = -$signed(mag[QUOT_W-1:0]);
      return {1'b0, q};
    end
    if (mag > POS_LIM) return {1'b1, QUOT_MAX};
    q = $signed(mag[QUOT_W-1:0]);
    return {1'b0, q};
  endfunction

`ifdef NETWORK_DIV_REM_EN
  function automatic logic signed [DIVISOR_W-1:0] apply_sign(input logic [DIVISOR_W-1:0] mag,
                                                             input logic neg);
    logic signed [DIVISOR_W-1:0] m;
    m = $signed(mag);
    return neg ? -m : m;
  endfunction
`endif

  always_comb begin
    {sat, quot} = sat_quot(q_mag, neg_n ^ neg_d);
    if (dbz) begin
      quot = neg_n ? QUOT_MIN : QUOT_MAX;
      sat  = 1'b0;
    end
`ifdef NETWORK_DIV_REM_EN
    rem = dbz ? dvd_lo : apply_sign(rem_mag, neg_n);
`endif
  end

endmodule

// File: rtl/network_div_seq_29s_13s_16.sv
// Radix-2 restoring signed divider, 29s / 13s -> 16s saturated, one quotient bit per cycle.
// Define NETWORK_DIV_REM_EN to expose the signed remainder on m_rem.
module network_div_seq_29s_13s_16
  import network_div_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DIVIDEND_W-1:0] s_dividend,
  input  logic [DIVISOR_W-1:0]  s_divisor,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [QUOT_W-1:0]     m_quot,
  output logic                  m_sat,
  output logic                  m_dbz
`ifdef NETWORK_DIV_REM_EN
  ,
  output logic [DIVISOR_W-1:0]  m_rem
`endif
);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  logic [DIVIDEND_W:0]    dvd_mag;
  logic [DIVISOR_W:0]     dvs_mag;
  logic [DIVIDEND_W:0]    q_mag;
  logic [DIVISOR_W:0]     rem_p;
  logic                   neg_n;
  logic                   neg_d;
  logic                   dbz;
`ifdef NETWORK_DIV_REM_EN
  logic [DIVISOR_W-1:0]   dvd_lo;
  logic [DIVISOR_W-1:0]   fix_rem;
`endif

  logic [DIVISOR_W+1:0]   trial;
  logic [DIVISOR_W:0]     diff;
  logic                   take;
  logic [QUOT_W-1:0]      fix_quot;
  logic                   fix_sat;

  // One extra bit so the most negative operands have exact magnitudes.
  function automatic logic [DIVIDEND_W:0] abs_dvd(input logic [DIVIDEND_W-1:0] v);
    logic signed [DIVIDEND_W:0] e;
    e = $signed({v[DIVIDEND_W-1], v});
    return (e < 0) ? -e : e;
  endfunction

  function automatic logic [DIVISOR_W:0] abs_dvs(input logic [DIVISOR_W-1:0] v);
    logic signed [DIVISOR_W:0] e;
    e = $signed({v[DIVISOR_W-1], v});
    return (e < 0) ? -e : e;
  endfunction

  always_comb begin
    trial = {rem_p, dvd_mag[cnt]};
    take  = (trial >= {1'b0, dvs_mag});
    diff  = trial[DIVISOR_W:0] - dvs_mag;
  end

  network_div_fix u_fix (
    .q_mag   (q_mag),
    .neg_n   (neg_n),
    .neg_d   (neg_d),
    .dbz     (dbz),
`ifdef NETWORK_DIV_REM_EN
    .rem_mag (rem_p[DIVISOR_W-1:0]),
    .dvd_lo  (dvd_lo),
    .rem     (fix_rem),
`endif
    .quot    (fix_quot),
    .sat     (fix_sat)
  );

  // Operand capture and shift datapath; these registers carry no reset.
  always_ff @(posedge ap_clk) begin
    if (state == IDLE && s_valid) begin
      dvd_mag <= abs_dvd(s_dividend);
      dvs_mag <= abs_dvs(s_divisor);
      neg_n   <= s_dividend[DIVIDEND_W-1];
      neg_d   <= s_divisor[DIVISOR_W-1];
      dbz     <= (s_divisor == '0);
`ifdef NETWORK_DIV_REM_EN
      dvd_lo  <= s_dividend[DIVISOR_W-1:0];
`endif
      q_mag   <= '0;
      rem_p   <= '0;
    end else if (state == CALC) begin
      q_mag   <= {q_mag[DIVIDEND_W-1:0], take};
      rem_p   <= take ? diff : trial[DIVISOR_W:0];
    end
  end

  // Control FSM and registered result outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_quot  <= '0;
      m_sat   <= 1'b0;
      m_dbz   <= 1'b0;
`ifdef NETWORK_DIV_REM_EN
      m_rem   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            cnt     <= CNT_W'(DIVIDEND_W-1);
            s_ready <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          m_quot  <= fix_quot;
          m_sat   <= fix_sat;
          m_dbz   <= dbz;
`ifdef NETWORK_DIV_REM_EN
          m_rem   <= fix_rem;
`endif
          m_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_network_div_seq_29s_13s_16.sv
// Directed bench for the sequential signed divider: signs, saturation, divide-by-zero, backpressure, reset.
module tb_network_div_seq_29s_13s_16;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        s_valid;
  logic        s_ready;
  logic [28:0] s_dividend;
  logic [12:0] s_divisor;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_quot;
  logic        m_sat;
  logic        m_dbz;
`ifdef NETWORK_DIV_REM_EN
  logic [12:0] m_rem;
`endif

  int passes = 0;
  int total  = 0;

  always #5 ap_clk = ~ap_clk;

  network_div_seq_29s_13s_16 dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_dividend (s_dividend),
    .s_divisor  (s_divisor),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_quot     (m_quot),
    .m_sat      (m_sat),
    .m_dbz      (m_dbz)
`ifdef NETWORK_DIV_REM_EN
    ,
    .m_rem      (m_rem)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic start_op(input string tag, input int dvd, input int dvs);
    int w;
    w = 0;
    while (!s_ready && w < 100) begin
      @(posedge ap_clk); #1;
      w++;
    end
    chk({tag, "_sready"}, int'(s_ready), 1);
    s_dividend = 29'(dvd);
    s_divisor  = 13'(dvs);
    s_valid    = 1'b1;
    @(posedge ap_clk); #1;
    s_valid    = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!m_valid && lat < 40) begin
      @(posedge ap_clk); #1;
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input int lat, input int q, input int sat,
                           input int dbz, input int rem);
    chk({tag, "_lat"}, lat, 30);
    chk({tag, "_quot"}, int'($signed(m_quot)), q);
    chk({tag, "_sat"}, int'(m_sat), sat);
    chk({tag, "_dbz"}, int'(m_dbz), dbz);
`ifdef NETWORK_DIV_REM_EN
    chk({tag, "_rem"}, int'($signed(m_rem)), rem);
`else
    if (rem != rem) $display("unreachable");
`endif
  endtask

  task automatic release_res();
    m_ready = 1'b1;
    @(posedge ap_clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic run(input string tag, input int dvd, input int dvs, input int q,
                     input int sat, input int dbz, input int rem);
    int lat;
    start_op(tag, dvd, dvs);
    wait_res(lat);
    check_res(tag, lat, q, sat, dbz, rem);
    release_res();
  endtask

  initial begin
    int lat;
    ap_rst     = 1'b1;
    s_valid    = 1'b0;
    m_ready    = 1'b0;
    s_dividend = '0;
    s_divisor  = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    chk("rst_sready", int'(s_ready), 1);
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_quot", int'(m_quot), 0);
    chk("rst_sat", int'(m_sat), 0);
    chk("rst_dbz", int'(m_dbz), 0);
`ifdef NETWORK_DIV_REM_EN
    chk("rst_rem", int'(m_rem), 0);
`endif

    run("p_div_p",   1000,       7,     142,    0, 0,   6);
    run("n_div_p",   -1000,      7,     -142,   0, 0,  -6);
    run("p_div_n",   1000,       -7,    -142,   0, 0,   6);
    run("n_div_n",   -1000,      -7,    142,    0, 0,  -6);
    run("max_div1",  268435455,  1,     32767,  1, 0,   0);
    run("min_divm1", -268435456, -1,    32767,  1, 0,   0);
    run("min_d4095", -268435456, 4095,  -32768, 1, 0, -16);
    run("min_dmin",  -268435456, -4096, 32767,  1, 0,   0);
    run("neg_edge",  -65536,     2,     -32768, 0, 0,   0);
    run("pos_edge",  65536,      2,     32767,  1, 0,   0);
    run("dbz_pos",   5,          0,     32767,  0, 1,   5);
    run("dbz_neg",   -5,         0,     -32768, 0, 1,  -5);
    run("dbz_zero",  0,          0,     32767,  0, 1,   0);

    // Backpressure: result must hold while m_ready stays low.
    start_op("bp", 1000, 3);
    wait_res(lat);
    check_res("bp", lat, 333, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk); #1;
      chk("bp_hold_quot", int'($signed(m_quot)), 333);
      chk("bp_hold_valid", int'(m_valid), 1);
      chk("bp_hold_sready", int'(s_ready), 0);
    end
    release_res();
    chk("bp_after_sready", int'(s_ready), 1);
    chk("bp_after_mvalid", int'(m_valid), 0);
    run("b2b", 300, -4, -75, 0, 0, 0);

    // Reset in the middle of CALC drops the in-flight result.
    start_op("rst_mid", 1000, 7);
    repeat (12) begin
      @(posedge ap_clk); #1;
    end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    chk("rst_mid_mvalid", int'(m_valid), 0);
    chk("rst_mid_sready", int'(s_ready), 1);
    run("post_rst", 84, 4, 21, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
